// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job sequencer.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT   = 16;
  localparam int GCD_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_RESP,
    S_CLEAR
  } gcd_seq_state_t;

endpackage

// File: rtl/gcd_seq_timer.sv
// WAIT-state watchdog: saturating up-counter with clear,
// enable and terminal count at TIMEOUT_CYCLES-1.
module gcd_seq_timer
  import gcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Request/response front end for the subtractive GCD engine.
// Optional WAIT timeout compiled in with GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] eng_data_in,
  output logic             eng_start,
  output logic             eng_rst,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err
);

  gcd_seq_state_t state, state_n;

  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] gcd_n, data_n;
  logic             err_n;
  logic             used, used_n;
  logic             tc;
  logic             a_z, b_z;

  assign a_z = (req_a == '0);
  assign b_z = (req_b == '0);

`ifdef GCD_SEQ_TIMEOUT_EN
  gcd_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state == S_CLEAR),
    .en (state == S_WAIT),
    .tc (tc)
  );
`else
  assign tc = 1'b0;
`endif

  always_comb begin
    state_n = state;
    b_n     = b_q;
    gcd_n   = rsp_gcd;
    err_n   = rsp_err;
    used_n  = used;
    unique case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          b_n    = req_b;
          used_n = 1'b0;
          err_n  = 1'b0;
          unique case (1'b1)
            (a_z && b_z): begin
              gcd_n   = '0;
              err_n   = 1'b1;
              state_n = S_RESP;
            end
            (a_z && !b_z): begin
              gcd_n   = req_b;
              state_n = S_RESP;
            end
            (!a_z && b_z): begin
              gcd_n   = req_a;
              state_n = S_RESP;
            end
            default: begin
              used_n  = 1'b1;
              state_n = S_LOAD_A;
            end
          endcase
        end
      end
      S_LOAD_A: state_n = S_LOAD_B;
      S_LOAD_B: state_n = S_WAIT;
      S_WAIT: begin
        // Engine completion has priority over the watchdog.
        if (eng_done) begin
          gcd_n   = eng_result;
          err_n   = 1'b0;
          state_n = S_RESP;
        end else if (tc) begin
          gcd_n   = '0;
          err_n   = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready)
          state_n = used ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    data_n = eng_data_in;
    if (state_n == S_LOAD_A)
      data_n = req_a;
    else if (state_n == S_LOAD_B)
      data_n = b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b0;
      eng_start   <= 1'b0;
      eng_data_in <= '0;
      eng_rst     <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_gcd     <= '0;
      rsp_err     <= 1'b0;
      b_q         <= '0;
      used        <= 1'b0;
    end else begin
      state       <= state_n;
      req_ready   <= (state_n == S_IDLE);
      eng_start   <= (state_n == S_LOAD_A);
      eng_data_in <= data_n;
      eng_rst     <= (state_n == S_CLEAR);
      rsp_valid   <= (state_n == S_RESP);
      rsp_gcd     <= gcd_n;
      rsp_err     <= err_n;
      b_q         <= b_n;
      used        <= used_n;
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a behavioural
// engine model; timeout expectations follow GCD_SEQ_TIMEOUT_EN.
module tb_gcd_job_sequencer;

  localparam int W = 16;
  localparam int T = 8;

  logic         clk = 0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b;
  logic [W-1:0] eng_data_in;
  logic         eng_start, eng_rst;
  logic         eng_done;
  logic [W-1:0] eng_result;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_gcd;
  logic         rsp_err;

  gcd_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .eng_data_in(eng_data_in), .eng_start(eng_start),
    .eng_rst(eng_rst), .eng_done(eng_done),
    .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_gcd(rsp_gcd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return W'(a);
  endfunction

  function automatic exp_t ref_rsp(input int a, input int b);
    exp_t r;
    r.e = 1'b0;
    if (a == 0 && b == 0) begin
      r.g = '0;
      r.e = 1'b1;
    end else if (a == 0) r.g = W'(b);
    else if (b == 0) r.g = W'(a);
    else r.g = gcd_ref(a, b);
    return r;
  endfunction

  // Behavioural engine: A on start cycle, B next, done after eng_lat.
  int           eng_lat = 1;
  bit           eng_hang = 0;
  int           e_ph = 0;
  int           e_cnt = 0;
  logic [W-1:0] e_a, e_b;

  function automatic logic [W-1:0] sub_gcd(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    while (a != b) begin
      if (a > b) a = a - b;
      else b = b - a;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (eng_rst) begin
      e_ph     <= 0;
      eng_done <= 1'b0;
      eng_result <= '0;
    end else if (eng_start) begin
      e_a  <= eng_data_in;
      e_ph <= 1;
    end else if (e_ph == 1) begin
      e_b <= eng_data_in;
      if (eng_hang) e_ph <= 3;
      else if (eng_lat <= 1) begin
        eng_done   <= 1'b1;
        eng_result <= sub_gcd(e_a, eng_data_in);
        e_ph       <= 3;
      end else begin
        e_cnt <= eng_lat - 1;
        e_ph  <= 2;
      end
    end else if (e_ph == 2) begin
      if (e_cnt == 1) begin
        eng_done   <= 1'b1;
        eng_result <= sub_gcd(e_a, e_b);
        e_ph       <= 3;
      end
      e_cnt <= e_cnt - 1;
    end
  end

  // Response consumer.
  bit hold_rdy = 0;
  bit rnd_rdy = 0;

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_rdy) rsp_ready = 1'b0;
      else if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
      else rsp_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pops, stability and pulse bookkeeping.
  int           rst_hi = 0;
  int           st_hi = 0;
  bit           pend = 0;
  logic [W-1:0] pg;
  logic         pe;

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      pend = 0;
    end else begin
      if (eng_rst) rst_hi++;
      if (eng_start) st_hi++;
      if (rsp_valid && req_ready)
        chk("req_ready_in_resp", req_ready, 0);
      if (pend) begin
        chk("rsp_valid_hold", rsp_valid, 1);
        chk("rsp_gcd_hold", rsp_gcd, pg);
        chk("rsp_err_hold", rsp_err, pe);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          x = exp_q.pop_front();
          chk("rsp_gcd", rsp_gcd, x.g);
          chk("rsp_err", rsp_err, x.e);
        end
      end
      pend = rsp_valid && !rsp_ready;
      pg   = rsp_gcd;
      pe   = rsp_err;
    end
  end

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_data_in"}, eng_data_in, 0);
    chk({tag, "_eng_rst"}, eng_rst, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_gcd"}, rsp_gcd, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   r0, s0, lat, seen;
    int   a, b, f;
    exp_t x;
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_eng_rst", eng_rst, 0);

    // 12/18 load sequence and clear pulse.
    eng_lat = 3;
    r0 = rst_hi;
    exp_q.push_back(ref_rsp(12, 18));
    do_req(12, 18);
    @(negedge clk);
    chk("loadA_start", eng_start, 1);
    chk("loadA_data", eng_data_in, 12);
    @(negedge clk);
    chk("loadB_start", eng_start, 0);
    chk("loadB_data", eng_data_in, 18);
    @(negedge clk);
    chk("wait_data", eng_data_in, 18);
    wait_rsp();
    repeat (4) @(negedge clk);
    chk("clear_pulse_len", rst_hi - r0, 1);

    // Zero-operand short circuits.
    r0 = rst_hi;
    s0 = st_hi;
    exp_q.push_back(ref_rsp(0, 35));
    do_req(0, 35);
    @(negedge clk);
    chk("zero_rsp_latency", rsp_valid, 1);
    wait_rsp();
    exp_q.push_back(ref_rsp(0, 0));
    do_req(0, 0);
    wait_rsp();
    repeat (3) @(negedge clk);
    chk("zero_no_start", st_hi - s0, 0);
    chk("zero_no_clear", rst_hi - r0, 0);

    // Back-pressure on 21/14.
    hold_rdy = 1;
    eng_lat = 2;
    exp_q.push_back(ref_rsp(21, 14));
    do_req(21, 14);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("bp_rsp_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_gcd", rsp_gcd, 7);
      chk("bp_req_ready", req_ready, 0);
    end
    hold_rdy = 0;
    wait_rsp();
    repeat (2) @(negedge clk);
    chk("bp_done", rsp_valid, 0);

    // Engine never completes.
    eng_hang = 1;
    r0 = rst_hi;
`ifdef GCD_SEQ_TIMEOUT_EN
    x.g = '0;
    x.e = 1'b1;
    exp_q.push_back(x);
    do_req(5, 10);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    chk("timeout_latency", lat, 11);
    wait_rsp();
    repeat (4) @(negedge clk);
    chk("timeout_clear", rst_hi - r0, 1);
`else
    do_req(5, 10);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_timeout_wait", seen, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`endif
    eng_hang = 0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during WAIT, then a fresh job.
    eng_lat = 50;
    do_req(100, 75);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    repeat (3) @(negedge clk);
    chk("rst_hold_eng_rst", eng_rst, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    eng_lat = 2;
    exp_q.push_back(ref_rsp(9, 6));
    do_req(9, 6);
    wait_rsp();

    // Done coincides with the last WAIT cycle before timeout.
    eng_lat = T;
    exp_q.push_back(ref_rsp(40, 24));
    do_req(40, 24);
    wait_rsp();

    // Randomized jobs with random back-pressure.
    rnd_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      wait_rsp();
      eng_lat = $urandom_range(1, 6);
      f = $urandom_range(1, 50);
      a = ($urandom_range(0, 6) == 0) ? 0 : f * $urandom_range(1, 400);
      b = ($urandom_range(0, 6) == 0) ? 0 : f * $urandom_range(1, 400);
      exp_q.push_back(ref_rsp(a, b));
      do_req(W'(a), W'(b));
    end
    wait_rsp();
    rnd_rdy = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_job_sequencer.md
# gcd_job_sequencer

Initiator-side front end for the subtractive GCD engine (datapath plus controller). Accepts operand pairs over a valid/ready request channel and drives the engine's `start`/`data_in` load sequence: operand A in the first cycle, operand B in the second. It then waits for the engine's `done`, returns the result over a valid/ready response channel, and pulses the engine reset so the engine leaves its terminal done state before the next job. It also short-circuits zero operands, which would make the subtractive engine loop forever.

## Interface
- `WIDTH`, 16, operand/result width in bits.
- `TIMEOUT_CYCLES`, 1024, maximum WAIT cycles before a job is aborted; must be ≥ 2.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request operands valid.
- `req_ready`  out  1  sequencer can accept a request.
- `req_a`, `req_b`  in  WIDTH  operands, unsigned.
- `eng_data_in`  out  WIDTH  operand bus to the engine input mux.
- `eng_start`  out  1  engine start strobe.
- `eng_rst`  out  1  engine reset.
- `eng_done`  in  1  engine done.
- `eng_result`  in  WIDTH  engine A-register value; valid while `eng_done` = 1.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_gcd`  out  WIDTH  result.
- `rsp_err`  out  1  error flag: both operands zero, or timeout.

## Operation
- All outputs are registered. Under `rst`: state IDLE, `req_ready`=0, `eng_start`=0, `eng_data_in`=0, `eng_rst`=1, `rsp_valid`=0, `rsp_gcd`=0, `rsp_err`=0, timer=0.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP, CLEAR.
- **IDLE:** `req_ready`=1, `eng_rst`=0. On `req_valid && req_ready`, capture both operands, then:
  - a=0 and b=0: go to RESP with `rsp_gcd`=0, `rsp_err`=1. The engine is not used.
  - exactly one operand is zero: go to RESP with `rsp_gcd`=nonzero operand, `rsp_err`=0. The engine is not used.
  - otherwise: go to LOAD_A.
- **LOAD_A** (1 cycle): `eng_start`=1, `eng_data_in`=A.
- **LOAD_B** (1 cycle): `eng_start`=0, `eng_data_in`=B.
- **WAIT:** `eng_data_in` holds B, and the timer increments each cycle. If `eng_done`=1, capture `eng_result` into `rsp_gcd` with `rsp_err`=0 and go to RESP. If the timer reaches `TIMEOUT_CYCLES`−1, set `rsp_gcd`=0, `rsp_err`=1 and go to RESP. If both happen in the same cycle, `eng_done` wins.
- **RESP:** `rsp_valid`=1. `rsp_gcd` and `rsp_err` are stable until the handshake. On `rsp_valid && rsp_ready`, go to CLEAR if the engine was used for this job, otherwise to IDLE.
- **CLEAR** (1 cycle): `eng_rst`=1, timer cleared, then IDLE.
- `req_ready` is 0 in every state except IDLE. There is no request queueing.
- An `eng_done` asserted outside WAIT is ignored.
- `rst` asserted mid-job aborts the job immediately. No response is produced, and `eng_rst` is held high until `rst` deasserts.

## Timing
- Request handshake at edge N:
  - LOAD_A occupies cycle N+1 and LOAD_B cycle N+2.
  - WAIT begins in cycle N+3.
- A WAIT exit at edge M makes `rsp_valid` high from cycle M+1.
- Zero-operand request accepted at edge N: `rsp_valid` high in cycle N+1.
- Minimum request-to-request spacing:
  - engine jobs: 6 cycles (engine done latency + RESP + CLEAR);
  - zero-operand jobs: 2 cycles.
- A response accepted in the first RESP cycle costs one cycle; back-pressure stretches RESP without limit.

## Configuration
- `GCD_SEQ_TIMEOUT_EN` defined: the WAIT timer and the timeout abort are compiled in, as described above.
- Not defined: the timer logic is removed, and WAIT exits only on `eng_done`. `rsp_err` is then set only for a=b=0, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `gcd_pkg`:
  - state enum `gcd_seq_state_t`;
  - `GCD_WIDTH_DEFAULT` = 16;
  - `GCD_TIMEOUT_DEFAULT` = 1024.
- Sub-module `gcd_seq_timer`: saturating up-counter with clear, enable and terminal-count output, width `$clog2(TIMEOUT_CYCLES)`. It is instantiated only under `GCD_SEQ_TIMEOUT_EN`.

## Test plan
- The bench uses a behavioural engine model with configurable done latency.
- a=12, b=18 → `eng_start`=1 with `eng_data_in`=12 for one cycle, then `eng_data_in`=18. Response: `rsp_gcd`=6, `rsp_err`=0, followed by a 1-cycle `eng_rst` pulse.
- a=0, b=35 → `rsp_valid` one cycle after accept with `rsp_gcd`=35; `eng_start` and `eng_rst` never pulse. a=0, b=0 → `rsp_gcd`=0, `rsp_err`=1.
- Hold `rsp_ready`=0 for 10 cycles on a=21, b=14 → `rsp_valid`, `rsp_gcd`=7 stable throughout and `req_ready`=0 throughout; completes on the `rsp_ready` edge.
- Model never asserts done, `TIMEOUT_CYCLES`=8 → `rsp_err`=1 and `rsp_gcd`=0 after 8 WAIT cycles, then `eng_rst` pulse. Without the macro, WAIT persists indefinitely.
- Assert `rst` during WAIT → all outputs return to reset values asynchronously. The next job, a=9, b=6, returns 3.
- `eng_done` and timer terminal count coincide → result taken from the engine with `rsp_err`=0.
